// File: rtl/mainfsm_if.sv
// mainfsm_if: controller bus between the main FSM and the datapath; LinkW only with MAINFSM_BL_EN
interface mainfsm_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       NextPC;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       ALUOp;
`ifdef MAINFSM_BL_EN
   logic       LinkW;
   modport master (input Op, Funct,
                   output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW);
   modport slave (output Op, Funct,
                  input IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW);
`else
   modport master (input Op, Funct,
                   output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp);
   modport slave (output Op, Funct,
                  input IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp);
`endif
endinterface

// File: rtl/mainfsm.sv
// mainfsm: Moore main control FSM of the multicycle ARM controller; BRANCHLINK state with MAINFSM_BL_EN
module mainfsm #(
   parameter int STATE_W = 4
) (
   input  logic     clk,
   input  logic     reset,
   mainfsm_if.master bus
);
   localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
   localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
   localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
   localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
   localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
   localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
   localparam logic [STATE_W-1:0] S_EXR    = STATE_W'(6);
   localparam logic [STATE_W-1:0] S_EXI    = STATE_W'(7);
   localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
   localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(9);
   logic [STATE_W-1:0] r_state, w_next, w_br;
   logic w_fetch, w_decode, w_memadr, w_memrd, w_memwb, w_memwr, w_exr, w_exi, w_aluwb, w_branch, w_bl, w_br_any;
   always_ff @(posedge clk)
      r_state <= reset ? S_FETCH : w_next;
`ifdef MAINFSM_BL_EN
   localparam logic [STATE_W-1:0] S_BL = STATE_W'(10);
   assign w_br = bus.Funct[4] ? S_BL : S_BRANCH;
   assign w_bl = (r_state == S_BL);
   assign bus.LinkW = w_bl;
`else
   assign w_br = S_BRANCH;
   assign w_bl = 1'b0;
`endif
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:      w_next = S_DECODE;
         S_DECODE:     w_next = (bus.Op == 2'b00) ? (bus.Funct[5] ? S_EXI : S_EXR) :
                                (bus.Op == 2'b01) ? S_MEMADR :
                                (bus.Op == 2'b10) ? w_br : S_FETCH;
         S_MEMADR:     w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:      w_next = S_MEMWB;
         S_EXR, S_EXI: w_next = S_ALUWB;
         default:      w_next = S_FETCH;
      endcase
   end
   // unused encodings match no decode below, so every output drops to 0
   assign w_fetch  = (r_state == S_FETCH);
   assign w_decode = (r_state == S_DECODE);
   assign w_memadr = (r_state == S_MEMADR);
   assign w_memrd  = (r_state == S_MEMRD);
   assign w_memwb  = (r_state == S_MEMWB);
   assign w_memwr  = (r_state == S_MEMWR);
   assign w_exr    = (r_state == S_EXR);
   assign w_exi    = (r_state == S_EXI);
   assign w_aluwb  = (r_state == S_ALUWB);
   assign w_branch = (r_state == S_BRANCH);
   assign w_br_any = w_branch | w_bl;
   assign bus.IRWrite   = w_fetch;
   assign bus.NextPC    = w_fetch;
   assign bus.AdrSrc    = w_memrd | w_memwr;
   assign bus.ALUSrcA   = w_fetch | w_decode;
   assign bus.ALUSrcB   = {w_fetch | w_decode, w_memadr | w_exi | w_br_any};
   assign bus.ResultSrc = {w_fetch | w_decode | w_br_any, w_memwb};
   assign bus.RegW      = w_memwb | w_aluwb | w_bl;
   assign bus.MemW      = w_memwr;
   assign bus.Branch    = w_br_any;
   assign bus.ALUOp     = w_exr | w_exi;
endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Main control state machine of the multicycle ARM controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath mux selects and the unconditioned write strobes NextPC, RegW, MemW and Branch. The condition-logic block gates these strobes with the evaluated condition.
- Sits beside the ALU decoder inside the controller and takes Op and Funct from the instruction register.

Parameters:
STATE_W, 4, width of state register; must be >=4 to hold the 10 states.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
Op  in  2  instruction bits [27:26]
Funct  in  6  instruction bits [25:20]; Funct[5]=I, Funct[0]=L (load) for memory ops, Funct[4]=L (link) for branches
IRWrite  out  1  instruction register load enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register
ALUSrcA  out  1  ALU operand A select: 0=register A, 1=PC
ALUSrcB  out  2  ALU operand B select: 00=register B, 01=extended immediate, 10=constant 4
ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALU result
NextPC  out  1  PC update request (unconditional)
RegW  out  1  register write request (before condition gating)
MemW  out  1  memory write request (before condition gating)
Branch  out  1  branch request (before condition gating)
ALUOp  out  1  1 = ALU decoder uses Funct (data processing); 0 = ADD

Behaviour:
- Moore machine: every output is a pure function of the state register. No combinational path from Op or Funct to any output.
- State register is updated on the rising edge of clk.
- Reset: reset=1 at a clk edge sets state to FETCH. This is synchronous, with no asynchronous path. While in FETCH the outputs are the FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0, ALUOp=0, and all other outputs 0.
- Reset asserted in any state, mid-instruction included, aborts the instruction. The next state is FETCH and no further strobes from the aborted instruction are issued.
- Outputs per state; any output not listed is 0:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0
  - MEMRD: AdrSrc=1, ResultSrc=00
  - MEMWB: ResultSrc=01, RegW=1
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1
  - ALUWB: ResultSrc=00, RegW=1
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1
- Transitions (one per clk):
  - FETCH -> DECODE
  - DECODE, by Op:
    - Op=00 and Funct[5]=0 -> EXECUTER
    - Op=00 and Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (undefined instruction treated as a no-op; no strobes issued)
  - MEMADR -> MEMRD if Funct[0]=1, else MEMWR
  - MEMRD -> MEMWB
  - EXECUTER and EXECUTEI -> ALUWB
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH
- Latency in cycles, FETCH to FETCH: data processing 4, LDR 5, STR 4, B 3, undefined 2.
- Compare-type operations still pass through ALUWB with RegW=1. Suppressing the write for them is the ALU decoder's job.
- Illegal or unused state encodings: all outputs 0 and next state FETCH, so the machine recovers in one cycle.
- Op and Funct are sampled only in DECODE and MEMADR. They must be held stable by the instruction register from the cycle after FETCH onward.

Optional Feature:
MAINFSM_BL_EN
- Defined:
  - Adds output LinkW (1 bit) and state BRANCHLINK.
  - From DECODE, Op=10 with Funct[4]=1 goes to BRANCHLINK instead of BRANCH.
  - BRANCHLINK drives the BRANCH outputs plus RegW=1 and LinkW=1. LinkW tells the register-address mux to select R14 and the write data to be PC+4 (ResultSrc=10).
  - BRANCHLINK -> FETCH. BL latency is 3 cycles.
  - LinkW is 0 in all other states and on reset.
- Undefined: no LinkW port. Op=10 always goes to BRANCH regardless of Funct[4], and the state count stays at 10.

Test Plan:
- Reset held 2 cycles, then released -> in FETCH: IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10. One cycle later in DECODE: IRWrite=0, NextPC=0.
- Op=00, Funct=6'b001000 (ADD reg) -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=1 and ALUSrcB=00 in EXECUTER; RegW=1 only in ALUWB.
- Op=01, Funct=6'b011001 (LDR imm) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB. Then Funct=6'b011000 (STR) -> MEMWR with MemW=1 for exactly 1 cycle.
- Op=10 (B) -> Branch=1 for exactly 1 cycle in BRANCH, with ALUSrcB=01. Then Op=11 -> DECODE returns to FETCH, with RegW, MemW and Branch never 1.
- Reset pulsed for 1 cycle while in MEMRD during an LDR -> next state FETCH, and no MEMWB cycle (RegW stays 0).
- With MAINFSM_BL_EN: Op=10, Funct[4]=1 -> BRANCHLINK with Branch=1, RegW=1, LinkW=1. With the macro undefined, the same stimulus gives Branch=1 and RegW=0.
